scan_frame_decoder: RTL and testbench

SCAN_FRAME_DECODER -- requirements
Module: scan_frame_decoder

---
 rtl/scan_frame_decoder_pkg.sv | 29 ++
 rtl/scan_frame_decoder_seg7_decode.sv | 12 +
 rtl/scan_frame_decoder.sv | 138 +++++++++++++
 tb/tb_scan_frame_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/scan_frame_decoder_pkg.sv
// Shared constants for the scanned 7-segment frame decoder: segment patterns,
// blank/idle values, sample classification and a small low-bit counting helper.
package scan_frame_decoder_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_IDLE   = 8'hFF;

    // Entry h is the active-low {g,f,e,d,c,b,a} pattern for hex digit h.
    localparam logic [15:0][6:0] SEG_PATTERN = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        SMP_BLANK   = 2'd0,
        SMP_ACTIVE  = 2'd1,
        SMP_ILLEGAL = 2'd2
    } sample_kind_e;

    function automatic logic [3:0] count_low(input logic [7:0] an);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~an[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/scan_frame_decoder_seg7_decode.sv
// Hex digit to active-low 7-segment pattern; purely combinational.
// Latency 0, no flow control.
module seg7_decode
    import scan_frame_decoder_pkg::*;
(
    input  logic [3:0] hex_dat,
    output logic [6:0] seg_dat
);

    assign seg_dat = SEG_PATTERN[hex_dat];

endmodule

// File: rtl/scan_frame_decoder.sv
// Re-registers a scanned 7-segment display and reassembles the scanned digits into frames.
// Latency 1 cycle on every output; no backpressure, one sample accepted per refresh_clock.
module scan_frame_decoder
    import scan_frame_decoder_pkg::*;
#(
    parameter int IDLE_LIMIT = 16
) (
    input  logic        refresh_clock,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic [3:0]  dig_out,
    output logic [6:0]  seg,
    output logic [7:0]  an_q,
    output logic [31:0] frame_digits,
    output logic [7:0]  frame_mask,
    output logic        frame_valid,
    output logic        onehot_err
);

    localparam int IW = $clog2(IDLE_LIMIT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);

    sample_kind_e    kind;
    logic [2:0]      idx;
    logic [7:0]      idx_sel;
    logic [6:0]      dec_seg;

    logic [6:0]      seg_q, seg_d;
    logic [7:0]      an_drv_q, an_drv_d;
    logic [31:0]     frame_digits_q, frame_digits_d;
    logic [7:0]      frame_mask_q, frame_mask_d;
    logic            frame_valid_q, frame_valid_d;
    logic            onehot_err_q, onehot_err_d;
    logic [7:0][3:0] work_q, work_d;
    logic [7:0]      work_mask_q, work_mask_d;
    logic [2:0]      last_idx_q, last_idx_d;
    logic [IW-1:0]   idle_q, idle_d;

    seg7_decode u_seg7_decode (
        .hex_dat (dig_out),
        .seg_dat (dec_seg)
    );

    always_comb begin
        kind = SMP_BLANK;
        idx  = '0;
        if (AN == AN_IDLE) begin
            kind = SMP_BLANK;
        end else if (count_low(AN) == 4'd1) begin
            kind = SMP_ACTIVE;
        end else begin
            kind = SMP_ILLEGAL;
        end
        for (int i = 0; i < 8; i++) begin
            if (!AN[i]) begin
                idx = 3'(i);
            end
        end
        idx_sel = 8'h01 << idx;
    end

    always_comb begin
        seg_d          = SEG_BLANK;
        an_drv_d       = AN_IDLE;
        frame_digits_d = frame_digits_q;
        frame_mask_d   = frame_mask_q;
        frame_valid_d  = 1'b0;
        onehot_err_d   = 1'b0;
        work_d         = work_q;
        work_mask_d    = work_mask_q;
        last_idx_d     = last_idx_q;
        idle_d         = idle_q;

        case (kind)
            SMP_ACTIVE: begin
                seg_d    = dec_seg;
                an_drv_d = AN;
                // Revisiting a position at or below the last one means the scan wrapped.
                if (work_mask_q != '0 && idx <= last_idx_q) begin
                    frame_digits_d = work_q;
                    frame_mask_d   = work_mask_q;
                    frame_valid_d  = 1'b1;
                    work_mask_d    = idx_sel;
                end else begin
                    work_mask_d    = work_mask_q | idx_sel;
                end
                work_d[idx] = dig_out;
                last_idx_d  = idx;
                idle_d      = '0;
            end
            default: begin
                idle_d       = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
                onehot_err_d = (kind == SMP_ILLEGAL);
                // Clearing the mask makes the timeout publish fire only once.
                if (idle_d == IDLE_MAX && work_mask_q != '0) begin
                    frame_digits_d = work_q;
                    frame_mask_d   = work_mask_q;
                    frame_valid_d  = 1'b1;
                    work_mask_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge refresh_clock) begin
        if (reset) begin
            seg_q          <= SEG_BLANK;
            an_drv_q       <= AN_IDLE;
            frame_digits_q <= '0;
            frame_mask_q   <= '0;
            frame_valid_q  <= 1'b0;
            onehot_err_q   <= 1'b0;
            work_q         <= '0;
            work_mask_q    <= '0;
            last_idx_q     <= '0;
            idle_q         <= '0;
        end else begin
            seg_q          <= seg_d;
            an_drv_q       <= an_drv_d;
            frame_digits_q <= frame_digits_d;
            frame_mask_q   <= frame_mask_d;
            frame_valid_q  <= frame_valid_d;
            onehot_err_q   <= onehot_err_d;
            work_q         <= work_d;
            work_mask_q    <= work_mask_d;
            last_idx_q     <= last_idx_d;
            idle_q         <= idle_d;
        end
    end

    assign seg          = seg_q;
    assign an_q         = an_drv_q;
    assign frame_digits = frame_digits_q;
    assign frame_mask   = frame_mask_q;
    assign frame_valid  = frame_valid_q;
    assign onehot_err   = onehot_err_q;

endmodule

// File: tb/tb_scan_frame_decoder.sv
// Directed self-checking bench for scan_frame_decoder with hand-computed expectations.
module tb_scan_frame_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  an_s;
    logic [3:0]  dig_s;
    logic [6:0]  seg_o;
    logic [7:0]  an_q_o;
    logic [31:0] fd_o;
    logic [7:0]  fm_o;
    logic        fv_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    scan_frame_decoder #(.IDLE_LIMIT(16)) dut (
        .refresh_clock (clk),
        .reset         (rst),
        .AN            (an_s),
        .dig_out       (dig_s),
        .seg           (seg_o),
        .an_q          (an_q_o),
        .frame_digits  (fd_o),
        .frame_mask    (fm_o),
        .frame_valid   (fv_o),
        .onehot_err    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] an_of(input int i);
        logic [7:0] one;
        one = 8'h01 << i;
        return ~one;
    endfunction

    task automatic step(input logic [7:0] an, input logic [3:0] d);
        @(negedge clk);
        an_s  = an;
        dig_s = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        an_s  = 8'hFF;
        dig_s = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        an_s  = 8'hFF;
        dig_s = 4'h0;

        do_reset();
        check_val("rst_seg", 32'(seg_o), 32'h7F);
        check_val("rst_an", 32'(an_q_o), 32'hFF);
        check_val("rst_digits", fd_o, 32'h0);
        check_val("rst_mask", 32'(fm_o), 32'h0);
        check_val("rst_valid", 32'(fv_o), 32'h0);
        check_val("rst_err", 32'(err_o), 32'h0);

        // Full scan 0..7 then wrap on position 0
        for (int i = 0; i < 8; i++) begin
            step(an_of(i), 4'(i + 1));
            if (i == 0) begin
                check_val("s1_an0", 32'(an_q_o), 32'hFE);
                check_val("s1_seg0", 32'(seg_o), 32'h79);
            end
        end
        check_val("s1_novalid", 32'(fv_o), 32'h0);
        step(an_of(0), 4'h9);
        check_val("s1_valid", 32'(fv_o), 32'h1);
        check_val("s1_digits", fd_o, 32'h87654321);
        check_val("s1_mask", 32'(fm_o), 32'hFF);
        step(an_of(1), 4'h2);
        check_val("s1_pulse_end", 32'(fv_o), 32'h0);
        check_val("s1_hold", fd_o, 32'h87654321);

        // Partial scan with blanks, then wrap
        do_reset();
        step(an_of(0), 4'h5);
        step(an_of(1), 4'hA);
        step(an_of(2), 4'h0);
        step(an_of(3), 4'h3);
        step(8'hFF, 4'h0);
        step(8'hFF, 4'h0);
        check_val("s2_novalid", 32'(fv_o), 32'h0);
        step(an_of(0), 4'h1);
        check_val("s2_valid", 32'(fv_o), 32'h1);
        check_val("s2_digits", 32'(fd_o[15:0]), 32'h30A5);
        check_val("s2_mask", 32'(fm_o), 32'h0F);

        // Idle timeout publishes exactly once at the 16th blank sample
        do_reset();
        step(an_of(0), 4'h7);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(8'hFF, 4'h0);
            if (fv_o) pulses++;
            check_val($sformatf("s3_vld_%0d", k), 32'(fv_o), (k == 16) ? 32'h1 : 32'h0);
            if (k == 16) begin
                check_val("s3_mask", 32'(fm_o), 32'h01);
                check_val("s3_digit", 32'(fd_o[3:0]), 32'h7);
            end
        end
        check_val("s3_pulses", 32'(pulses), 32'h1);

        // Illegal sample: error pulse, blank outputs, no write, last_idx kept
        do_reset();
        step(an_of(3), 4'h4);
        step(8'b0111_0000, 4'h5);
        check_val("s4_err", 32'(err_o), 32'h1);
        check_val("s4_seg", 32'(seg_o), 32'h7F);
        check_val("s4_an", 32'(an_q_o), 32'hFF);
        check_val("s4_novalid", 32'(fv_o), 32'h0);
        step(8'hFF, 4'h0);
        check_val("s4_err_end", 32'(err_o), 32'h0);
        step(an_of(5), 4'h6);
        check_val("s4_nowrap", 32'(fv_o), 32'h0);
        step(an_of(0), 4'h1);
        check_val("s4_valid", 32'(fv_o), 32'h1);
        check_val("s4_mask", 32'(fm_o), 32'h28);
        check_val("s4_digits", fd_o, 32'h00604000);

        // Decode sweep on position 2
        do_reset();
        for (int h = 0; h < 16; h++) begin
            step(8'hFB, 4'(h));
            check_val($sformatf("s5_seg_%0d", h), 32'(seg_o), 32'(exp_seg[h]));
            check_val($sformatf("s5_an_%0d", h), 32'(an_q_o), 32'hFB);
        end

        // Reset mid-frame, coinciding with a wrap sample
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(an_of(i), 4'(i + 1));
        end
        @(negedge clk);
        rst   = 1'b1;
        an_s  = an_of(0);
        dig_s = 4'h7;
        @(posedge clk);
        #1;
        check_val("s6_rst_valid", 32'(fv_o), 32'h0);
        check_val("s6_rst_digits", fd_o, 32'h0);
        rst = 1'b0;
        step(an_of(0), 4'h7);
        check_val("s6_valid", 32'(fv_o), 32'h0);
        check_val("s6_digits", fd_o, 32'h0);
        check_val("s6_mask", 32'(fm_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
